pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
- Sequencer that drives the configuration inputs of the PWM `timer_counter`: `control`, `prescalor`, `max_count` and `compare`.
- Channel selection: on a start command it enables one of the four timer output channels.
- Duty ramp: it ramps the duty (`compare`) from 0 up to a target in fixed steps at a programmable interval, then holds.
- On a stop command it ramps the duty back down to 0 and disables the timer. Used for soft start/stop of the elevator motor and door drives.

Parameters:
- PRESCALER, 999, value driven on `prescalor` (constant).
- MAX_COUNT, 999, value driven on `max_count`; upper clamp for the duty target.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begin ramp-up (honoured only in IDLE)
- stop  in  1  single-cycle pulse; begin ramp-down (honoured only in RAMP_UP or HOLD)
- channel  in  2  timer output channel 0..3; latched on accepted start
- target  in  32  final duty value; latched on accepted start
- step  in  32  duty increment/decrement per interval; latched on accepted start
- interval  in  32  clocks between duty updates; latched on accepted start
- control  out  6  to timer_counter: bit0 = enable, bit1 = 0, bits[5:2] = one-hot channel (bit 2+channel)
- prescalor  out  32  to timer_counter; always PRESCALER
- max_count  out  32  to timer_counter; always MAX_COUNT
- compare  out  32  to timer_counter; current duty
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on reaching HOLD or on returning to IDLE
- state  out  2  IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3

Behaviour:
- All outputs are registered. Start/stop sampled at edge k take effect in the cycle after edge k.
- Reset values: control=0, compare=0, busy=0, done=0, state=IDLE. prescalor=PRESCALER and max_count=MAX_COUNT at all times, including during reset.
- Reset mid-operation: at the next edge all of the above return to their reset values; latched settings are discarded.
- Latching on accepted start:
  - tgt = min(target, MAX_COUNT)
  - stp = max(step, 1)
  - ivl = max(interval, 1)
  - ch = channel
- Interval counter `icnt`:
  - Cleared on every state change.
  - Counts 0..ivl-1 while in RAMP_UP or RAMP_DOWN.
  - A tick occurs in the cycle where icnt == ivl-1; icnt then wraps to 0.
- IDLE:
  - control=0, compare=0.
  - On start → RAMP_UP; control = {one-hot ch, 0, 1}; compare=0.
  - If tgt == 0, go directly to HOLD instead, with a done pulse.
  - stop is ignored. When start and stop coincide, start wins.
- RAMP_UP, on tick:
  - compare = min(compare+stp, tgt). The sum is computed at 33 bits so it cannot wrap.
  - If the new value == tgt → HOLD, with a done pulse in the same cycle the state becomes HOLD.
- HOLD: compare stays at tgt, control is unchanged, and icnt is idle.
- stop in RAMP_UP or HOLD:
  - → RAMP_DOWN; compare is unchanged that cycle.
  - If stop coincides with a tick, stop wins and no increment is applied.
- RAMP_DOWN, on tick:
  - compare = (compare > stp) ? compare-stp : 0.
  - When the new value is 0 → IDLE next, with control=0 and a done pulse.
  - start and stop are both ignored.
  - If RAMP_DOWN is entered with compare already 0, the first tick returns to IDLE.
- Commands: start outside IDLE is ignored. Input changes outside an accepted start have no effect.
- Timing: control stays constant for the whole non-IDLE period; only compare changes, and only on ticks.

Test Plan:
- Reset asserted 3 cycles → control=0, compare=0, prescalor=999, max_count=999, state=0, busy=0, done=0.
- start with channel=2, target=10, step=4, interval=3 → control=6'b010001 and state=1 the next cycle; compare goes 0→4→8→10 with updates 3 cycles apart; state=2 and a 1-cycle done pulse when compare reaches 10.
- From HOLD (compare=10), stop → state=3; compare goes 10→6→2→0 every 3 cycles; then state=0, control=6'b000000, done pulse.
- start with channel=0, target=2000, step=500, interval=1 → control=6'b000101; compare goes 500→999; HOLD reached with compare=999.
- start with target=10, step=0, interval=0 → compare increments by 1 every cycle and reaches 10 after 10 cycles. Then stop asserted in the same cycle as a tick while ramping → no increment applied and state=3.
- Mid RAMP_UP (compare=4): assert reset 1 cycle → next cycle control=0, compare=0, state=0. A start pulse during RAMP_UP or HOLD → ignored (channel, target and compare unchanged).

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft start/stop sequencer for the PWM timer_counter.
// On start it enables one timer channel and ramps the duty (compare) up to
// a target in fixed steps at a programmable interval, then holds. On stop
// it ramps the duty back to zero and disables the timer.
module pwm_ramp_ctrl #(
  parameter logic [31:0] PRESCALER = 32'd999,
  parameter logic [31:0] MAX_COUNT = 32'd999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  channel,
  input  logic [31:0] target,
  input  logic [31:0] step,
  input  logic [31:0] interval,
  output logic [5:0]  control,
  output logic [31:0] prescalor,
  output logic [31:0] max_count,
  output logic [31:0] compare,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_HOLD      = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  state_t      state_q;
  logic [5:0]  control_q;
  logic [31:0] compare_q;
  logic        busy_q;
  logic        done_q;

  // Settings captured on an accepted start; the channel lives in control_q.
  logic [31:0] tgt_q;
  logic [31:0] stp_q;
  logic [31:0] ivl_q;
  logic [31:0] icnt_q;

  // Sanitised versions of the command inputs, used only when start is accepted.
  logic [31:0] tgt_d;
  logic [31:0] stp_d;
  logic [31:0] ivl_d;
  logic [5:0]  control_d;

  // Candidate duty values for the next tick.
  logic [32:0] up_sum;
  logic [31:0] compare_up_d;
  logic [31:0] compare_dn_d;
  logic        tick;

  // Clamp target, force step/interval to at least 1, and build the enable word.
  always_comb begin
    tgt_d = (target > MAX_COUNT) ? MAX_COUNT : target;
    stp_d = (step == '0) ? 32'd1 : step;
    ivl_d = (interval == '0) ? 32'd1 : interval;
    control_d = 6'b000001;
    case (channel)
      2'd0: control_d = 6'b000101;
      2'd1: control_d = 6'b001001;
      2'd2: control_d = 6'b010001;
      2'd3: control_d = 6'b100001;
      default: control_d = 6'b000001;
    endcase
  end

  // Tick detection and next duty values; the up sum is 33 bits so a huge step cannot wrap.
  always_comb begin
    tick         = (icnt_q == (ivl_q - 32'd1));
    up_sum       = {1'b0, compare_q} + {1'b0, stp_q};
    compare_up_d = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[31:0];
    compare_dn_d = (compare_q > stp_q) ? (compare_q - stp_q) : '0;
  end

  // Sequencer FSM with registered outputs and interval counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      control_q <= '0;
      compare_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tgt_q     <= '0;
      stp_q     <= '0;
      ivl_q     <= '0;
      icnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          control_q <= '0;
          compare_q <= '0;
          icnt_q    <= '0;
          if (start) begin
            tgt_q     <= tgt_d;
            stp_q     <= stp_d;
            ivl_q     <= ivl_d;
            control_q <= control_d;
            busy_q    <= 1'b1;
            if (tgt_d == '0) begin
              state_q <= S_HOLD;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RAMP_UP;
            end
          end
        end

        S_RAMP_UP: begin
          // stop has priority over a coincident tick: no increment is applied.
          if (stop) begin
            state_q <= S_RAMP_DOWN;
            icnt_q  <= '0;
          end else if (tick) begin
            compare_q <= compare_up_d;
            icnt_q    <= '0;
            if (compare_up_d == tgt_q) begin
              state_q <= S_HOLD;
              done_q  <= 1'b1;
            end
          end else begin
            icnt_q <= icnt_q + 32'd1;
          end
        end

        S_HOLD: begin
          icnt_q <= '0;
          if (stop) begin
            state_q <= S_RAMP_DOWN;
          end
        end

        S_RAMP_DOWN: begin
          if (tick) begin
            compare_q <= compare_dn_d;
            icnt_q    <= '0;
            if (compare_dn_d == '0) begin
              state_q   <= S_IDLE;
              control_q <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end
          end else begin
            icnt_q <= icnt_q + 32'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign control   = control_q;
  assign compare   = compare_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state     = state_q;
  assign prescalor = PRESCALER;
  assign max_count = MAX_COUNT;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: table-driven vectors, hand sequences for multi-cycle
// corners, and randomized commands checked against a behavioural model.
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [1:0]  channel;
  logic [31:0] target, step, interval;
  logic [5:0]  control;
  logic [31:0] prescalor, max_count, compare;
  logic        busy, done;
  logic [1:0]  state;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.PRESCALER(32'd999), .MAX_COUNT(32'd999)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .channel(channel),
    .target(target), .step(step), .interval(interval), .control(control),
    .prescalor(prescalor), .max_count(max_count), .compare(compare),
    .busy(busy), .done(done), .state(state)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic expect_outs(input string tag, input logic [5:0] ec, input logic [31:0] ecmp,
                             input logic [1:0] est, input logic ed);
    chk({tag, ".control"}, control, ec);
    chk({tag, ".compare"}, compare, ecmp);
    chk({tag, ".state"}, state, est);
    chk({tag, ".done"}, done, ed);
    chk({tag, ".busy"}, busy, (est != 2'd0));
    chk({tag, ".prescalor"}, prescalor, 999);
    chk({tag, ".max_count"}, max_count, 999);
  endtask

  // Apply one set of inputs across one rising edge, then settle away from the edge.
  task automatic cyc(input logic r, input logic s, input logic p, input logic [1:0] ch,
                     input logic [31:0] tg, input logic [31:0] sz, input logic [31:0] iv);
    reset = r; start = s; stop = p; channel = ch; target = tg; step = sz; interval = iv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 2'd1, 32'd5, 32'd1, 32'd1);
  endtask

  typedef struct {
    logic        rst, st, sp;
    logic [1:0]  ch;
    logic [31:0] tg, sz, iv;
    logic [5:0]  e_ctl;
    logic [31:0] e_cmp;
    logic [1:0]  e_st;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic sp, input logic [1:0] ch,
                              input logic [31:0] tg, input logic [31:0] sz, input logic [31:0] iv,
                              input logic [5:0] e_ctl, input logic [31:0] e_cmp,
                              input logic [1:0] e_st, input logic e_done);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.ch = ch; v.tg = tg; v.sz = sz; v.iv = iv;
    v.e_ctl = e_ctl; v.e_cmp = e_cmp; v.e_st = e_st; v.e_done = e_done;
    return v;
  endfunction

  // Behavioural reference: duty updates every ivl cycles, tracked as a countdown.
  int               m_mode;
  longint unsigned  m_cmp, m_tgt, m_stp, m_ivl, m_left;
  logic [5:0]       m_ctl;
  bit               m_done;

  task automatic model_step(input bit r, input bit s, input bit p, input int ch,
                            input longint unsigned tg, input longint unsigned sz,
                            input longint unsigned iv);
    m_done = 1'b0;
    if (r) begin
      m_mode = 0; m_cmp = 0; m_ctl = '0; m_tgt = 0; m_stp = 0; m_ivl = 0; m_left = 0;
      return;
    end
    case (m_mode)
      0: if (s) begin
        m_tgt  = (tg > 999) ? 999 : tg;
        m_stp  = (sz == 0) ? 1 : sz;
        m_ivl  = (iv == 0) ? 1 : iv;
        m_ctl  = 6'(1 << (2 + ch)) | 6'd1;
        m_cmp  = 0;
        m_left = m_ivl;
        if (m_tgt == 0) begin m_mode = 2; m_done = 1'b1; end
        else m_mode = 1;
      end
      1: if (p) begin
        m_mode = 3; m_left = m_ivl;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_left = m_ivl;
          m_cmp  = (m_cmp + m_stp > m_tgt) ? m_tgt : m_cmp + m_stp;
          if (m_cmp == m_tgt) begin m_mode = 2; m_done = 1'b1; end
        end
      end
      2: if (p) begin
        m_mode = 3; m_left = m_ivl;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_left = m_ivl;
          m_cmp  = (m_cmp > m_stp) ? m_cmp - m_stp : 0;
          if (m_cmp == 0) begin m_mode = 0; m_ctl = '0; m_done = 1'b1; end
        end
      end
    endcase
  endtask

  initial begin
    bit found;
    reset = 1'b1; start = 1'b0; stop = 1'b0; channel = '0; target = '0; step = '0; interval = '0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0, 2'd0, 0,0,0, 6'h00, 0, 2'd0, 0));
    vecs.push_back(mk(0,0,0, 2'd0, 0,0,0, 6'h00, 0, 2'd0, 0));
    vecs.push_back(mk(0,1,0, 2'd2, 10,4,3, 6'b010001, 0, 2'd1, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 0, 2'd1, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 0, 2'd1, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 4, 2'd1, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 4, 2'd1, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 4, 2'd1, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 8, 2'd1, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 8, 2'd1, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 8, 2'd1, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 10, 2'd2, 1));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 10, 2'd2, 0));
    vecs.push_back(mk(0,1,0, 2'd3, 500,9,1, 6'b010001, 10, 2'd2, 0));
    vecs.push_back(mk(0,0,1, 2'd1, 5,1,1, 6'b010001, 10, 2'd3, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 10, 2'd3, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 10, 2'd3, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 6, 2'd3, 0));
    vecs.push_back(mk(0,1,0, 2'd1, 5,1,1, 6'b010001, 6, 2'd3, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 6, 2'd3, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 2, 2'd3, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 2, 2'd3, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b010001, 2, 2'd3, 0));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b000000, 0, 2'd0, 1));
    vecs.push_back(mk(0,0,0, 2'd1, 5,1,1, 6'b000000, 0, 2'd0, 0));
    vecs.push_back(mk(0,0,1, 2'd1, 5,1,1, 6'b000000, 0, 2'd0, 0));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].ch, vecs[i].tg, vecs[i].sz, vecs[i].iv);
      expect_outs($sformatf("vec%0d", i), vecs[i].e_ctl, vecs[i].e_cmp, vecs[i].e_st, vecs[i].e_done);
    end

    // ---------------- target clamped to MAX_COUNT ----------------
    cyc(0, 1, 0, 2'd0, 32'd2000, 32'd500, 32'd1);
    expect_outs("clamp.start", 6'b000101, 0, 2'd1, 0);
    idle_cyc(); expect_outs("clamp.s1", 6'b000101, 500, 2'd1, 0);
    idle_cyc(); expect_outs("clamp.s2", 6'b000101, 999, 2'd2, 1);
    cyc(0, 0, 1, 2'd1, 5, 1, 1); expect_outs("clamp.stop", 6'b000101, 999, 2'd3, 0);
    idle_cyc(); expect_outs("clamp.d1", 6'b000101, 499, 2'd3, 0);
    idle_cyc(); expect_outs("clamp.d2", 6'b000000, 0, 2'd0, 1);

    // ---------------- step=0, interval=0 behave as 1 ----------------
    cyc(0, 1, 0, 2'd3, 32'd10, 32'd0, 32'd0);
    expect_outs("unit.start", 6'b100001, 0, 2'd1, 0);
    for (int i = 1; i <= 10; i++) begin
      idle_cyc();
      expect_outs($sformatf("unit.up%0d", i), 6'b100001, i, (i == 10) ? 2'd2 : 2'd1, (i == 10));
    end
    cyc(0, 0, 1, 2'd1, 5, 1, 1); expect_outs("unit.stop", 6'b100001, 10, 2'd3, 0);
    for (int i = 1; i <= 10; i++) begin
      idle_cyc();
      expect_outs($sformatf("unit.dn%0d", i), (i == 10) ? 6'b000000 : 6'b100001, 10 - i,
                  (i == 10) ? 2'd0 : 2'd3, (i == 10));
    end

    // ---------------- stop coinciding with a tick ----------------
    cyc(0, 1, 0, 2'd3, 32'd10, 32'd0, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      idle_cyc(); expect_outs($sformatf("coin.up%0d", i), 6'b100001, i, 2'd1, 0);
    end
    cyc(0, 0, 1, 2'd1, 5, 1, 1); expect_outs("coin.stop", 6'b100001, 3, 2'd3, 0);
    idle_cyc(); expect_outs("coin.d1", 6'b100001, 2, 2'd3, 0);
    idle_cyc(); expect_outs("coin.d2", 6'b100001, 1, 2'd3, 0);
    idle_cyc(); expect_outs("coin.d3", 6'b000000, 0, 2'd0, 1);

    // ---------------- reset mid ramp, then ignored start ----------------
    cyc(0, 1, 0, 2'd1, 32'd10, 32'd4, 32'd3);
    expect_outs("rst.start", 6'b001001, 0, 2'd1, 0);
    idle_cyc(); idle_cyc(); idle_cyc();
    expect_outs("rst.cmp4", 6'b001001, 4, 2'd1, 0);
    cyc(1, 0, 0, 2'd1, 5, 1, 1); expect_outs("rst.mid", 6'b000000, 0, 2'd0, 0);
    idle_cyc(); expect_outs("rst.after", 6'b000000, 0, 2'd0, 0);
    cyc(0, 1, 0, 2'd1, 32'd10, 32'd4, 32'd3);
    expect_outs("ign.start", 6'b001001, 0, 2'd1, 0);
    cyc(0, 1, 0, 2'd3, 32'd500, 32'd100, 32'd1);
    expect_outs("ign.restart", 6'b001001, 0, 2'd1, 0);
    begin
      logic [31:0] exp_cmp [7];
      exp_cmp = '{0, 4, 4, 4, 8, 8, 8};
      for (int i = 0; i < 7; i++) begin
        idle_cyc(); expect_outs($sformatf("ign.up%0d", i), 6'b001001, exp_cmp[i], 2'd1, 0);
      end
    end
    idle_cyc(); expect_outs("ign.hold", 6'b001001, 10, 2'd2, 1);
    cyc(0, 1, 0, 2'd0, 32'd3, 32'd1, 32'd1); expect_outs("ign.hstart", 6'b001001, 10, 2'd2, 0);
    cyc(0, 0, 1, 2'd1, 5, 1, 1); expect_outs("ign.stop", 6'b001001, 10, 2'd3, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      idle_cyc();
      if (state == 2'd0) found = 1'b1;
    end
    chk("ign.drain_in_time", found, 1);
    expect_outs("ign.idle", 6'b000000, 0, 2'd0, 1);

    // ---------------- zero target goes straight to HOLD ----------------
    cyc(0, 1, 0, 2'd2, 32'd0, 32'd7, 32'd2);
    expect_outs("zero.start", 6'b010001, 0, 2'd2, 1);
    idle_cyc(); expect_outs("zero.hold", 6'b010001, 0, 2'd2, 0);
    cyc(0, 0, 1, 2'd1, 5, 1, 1); expect_outs("zero.stop", 6'b010001, 0, 2'd3, 0);
    idle_cyc(); expect_outs("zero.wait", 6'b010001, 0, 2'd3, 0);
    idle_cyc(); expect_outs("zero.idle", 6'b000000, 0, 2'd0, 1);

    // ---------------- randomized commands vs reference model ----------------
    cyc(1, 0, 0, 2'd0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit          r, s, p;
      logic [1:0]  ch;
      logic [31:0] tg, sz, iv;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 19) == 0);
      p  = ($urandom_range(0, 29) == 0);
      ch = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: tg = $urandom;
        1: tg = 32'd0;
        default: tg = $urandom_range(0, 60);
      endcase
      case ($urandom_range(0, 5))
        0: sz = 32'd0;
        1: sz = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        2: sz = $urandom_range(50, 300);
        default: sz = $urandom_range(1, 9);
      endcase
      iv = $urandom_range(0, 3);
      cyc(r, s, p, ch, tg, sz, iv);
      model_step(r, s, p, int'(ch), tg, sz, iv);
      chk($sformatf("rnd%0d.control", n), control, m_ctl);
      chk($sformatf("rnd%0d.compare", n), compare, m_cmp);
      chk($sformatf("rnd%0d.state", n), state, m_mode);
      chk($sformatf("rnd%0d.done", n), done, m_done);
      chk($sformatf("rnd%0d.busy", n), busy, (m_mode != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
